// File: rtl/inst_loader_pkg.sv
// Shared types and constants for the boot loader that fills instruction memory
// from a framed byte stream before releasing the core.
package inst_loader_pkg;

  typedef enum logic [2:0] {
    LDR_IDLE   = 3'd0,
    LDR_LEN_LO = 3'd1,
    LDR_LEN_HI = 3'd2,
    LDR_DATA   = 3'd3,
    LDR_CSUM   = 3'd4,
    LDR_DONE   = 3'd5,
    LDR_ERR    = 3'd6
  } ldr_state_e;

  localparam logic [7:0] LDR_MAGIC = 8'hA5;

  // States in which a frame is in flight and the inter-byte timeout runs.
  function automatic logic ldr_in_frame(input ldr_state_e s);
    return (s == LDR_LEN_LO) || (s == LDR_LEN_HI) ||
           (s == LDR_DATA)   || (s == LDR_CSUM);
  endfunction

endpackage

// File: rtl/inst_loader_timer.sv
// Inter-byte watchdog: reloads on every accepted byte, counts down while a frame
// is in flight and flags expiry on the cycle the idle budget is used up.
module inst_loader_timer #(
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic reload,
  output logic expire
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] LOAD = CW'(TIMEOUT_CYC);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (!run) begin
      cnt <= '0;
    end else if (reload) begin
      cnt <= LOAD;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Last idle cycle of the budget: the count only holds 1 here if no byte arrived.
  assign expire = !reload && (cnt == CW'(1));

endmodule

// File: rtl/inst_loader.sv
// Boot loader: parses A5/LEN/DATA/CSUM frames, packs bytes little-endian into
// instruction-memory writes and holds the core until a verified frame is stored.
module inst_loader
  import inst_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter logic [15:0] MAX_WORDS   = 16'd4096,
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid_i,
  input  logic [7:0]  rx_data_i,
  output logic        rx_ready_o,
  output logic        rom_we_o,
  output logic [31:0] rom_addr_o,
  output logic [31:0] rom_data_o,
  output logic        core_hold_o,
  output logic        boot_done_o,
  output logic        boot_err_o,
  output logic [15:0] words_o,
  output ldr_state_e  dbg_state_o
);

  // Byte handshake: a byte moves on a cycle where rx_valid_i and rx_ready_o are
  // both high; rx_ready_o depends only on registers, never on rx_valid_i.

  ldr_state_e  state_q, state_next;
  logic [15:0] len_q;
  logic [15:0] words_q;
  logic [7:0]  csum_q;
  logic [1:0]  lane_q;
  logic [23:0] pack_q;
  logic        rom_we_q;
  logic [31:0] rom_addr_q;
  logic [31:0] rom_data_q;
  logic        xfer;
  logic        is_magic;
  logic [15:0] len_n;
  logic        timer_expire;

  assign rx_ready_o  = (state_q != LDR_DONE) && !rom_we_q;
  assign xfer        = rx_valid_i && rx_ready_o;
  assign is_magic    = (rx_data_i == LDR_MAGIC);
  assign len_n       = {rx_data_i, len_q[7:0]};

  assign rom_we_o    = rom_we_q;
  assign rom_addr_o  = rom_addr_q;
  assign rom_data_o  = rom_data_q;
  assign words_o     = words_q;
  assign core_hold_o = (state_q != LDR_DONE);
  assign boot_done_o = (state_q == LDR_DONE);
  assign boot_err_o  = (state_q == LDR_ERR);
  assign dbg_state_o = state_q;

  inst_loader_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .run    (ldr_in_frame(state_next)),
    .reload (xfer),
    .expire (timer_expire)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= LDR_IDLE;
    end else begin
      state_q <= state_next;
    end
  end

  always_comb begin
    state_next = state_q;
    unique case (state_q)
      LDR_IDLE: begin
        if (xfer && is_magic) state_next = LDR_LEN_LO;
      end
      LDR_LEN_LO: begin
        if (xfer) state_next = LDR_LEN_HI;
      end
      LDR_LEN_HI: begin
        if (xfer) begin
          if (len_n > MAX_WORDS)    state_next = LDR_ERR;
          else if (len_n == 16'd0)  state_next = LDR_CSUM;
          else                      state_next = LDR_DATA;
        end
      end
      LDR_DATA: begin
        if (xfer && (lane_q == 2'd3) && (words_q + 16'd1 == len_q)) state_next = LDR_CSUM;
      end
      LDR_CSUM: begin
        if (xfer) state_next = (rx_data_i == csum_q) ? LDR_DONE : LDR_ERR;
      end
      LDR_DONE: begin
        state_next = LDR_DONE;
      end
      LDR_ERR: begin
        if (xfer && is_magic) state_next = LDR_LEN_LO;
      end
      default: state_next = LDR_IDLE;
    endcase
    if (timer_expire && ldr_in_frame(state_q)) state_next = LDR_ERR;
  end

  // Datapath: length capture, checksum, byte packing and the write strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_q      <= '0;
      words_q    <= '0;
      csum_q     <= '0;
      lane_q     <= '0;
      pack_q     <= '0;
      rom_we_q   <= 1'b0;
      rom_addr_q <= '0;
      rom_data_q <= '0;
    end else begin
      rom_we_q <= 1'b0;
      if (xfer) begin
        case (state_q)
          LDR_IDLE, LDR_ERR: begin
            if (is_magic) begin
              words_q <= '0;
              csum_q  <= '0;
              lane_q  <= '0;
            end
          end
          LDR_LEN_LO: begin
            len_q[7:0] <= rx_data_i;
            csum_q     <= csum_q ^ rx_data_i;
          end
          LDR_LEN_HI: begin
            len_q[15:8] <= rx_data_i;
            csum_q      <= csum_q ^ rx_data_i;
          end
          LDR_DATA: begin
            csum_q <= csum_q ^ rx_data_i;
            lane_q <= lane_q + 2'd1;
            case (lane_q)
              2'd0: pack_q[7:0]   <= rx_data_i;
              2'd1: pack_q[15:8]  <= rx_data_i;
              2'd2: pack_q[23:16] <= rx_data_i;
              default: begin
                rom_we_q   <= 1'b1;
                rom_addr_q <= BASE_ADDR + {14'd0, words_q, 2'b00};
                rom_data_q <= {rx_data_i, pack_q};
                words_q    <= words_q + 16'd1;
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_inst_loader.sv
// Bench for inst_loader: byte driver, write scoreboard fed from the frames sent,
// and one task per scenario.
module tb_inst_loader;
  import inst_loader_pkg::*;

  localparam int unsigned TB_TIMEOUT = 40;
  localparam logic [31:0] TB_BASE    = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready;
  logic        rom_we;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic        core_hold;
  logic        boot_done;
  logic        boot_err;
  logic [15:0] words;
  ldr_state_e  dbg_state;

  int checks = 0;
  int failures = 0;
  logic [79:0] exp_q[$];
  logic [31:0] frame_words[16];

  inst_loader #(
    .BASE_ADDR  (TB_BASE),
    .MAX_WORDS  (16'd4096),
    .TIMEOUT_CYC(TB_TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_valid_i (rx_valid),
    .rx_data_i  (rx_data),
    .rx_ready_o (rx_ready),
    .rom_we_o   (rom_we),
    .rom_addr_o (rom_addr),
    .rom_data_o (rom_data),
    .core_hold_o(core_hold),
    .boot_done_o(boot_done),
    .boot_err_o (boot_err),
    .words_o    (words),
    .dbg_state_o(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic do_reset();
    rx_valid = 1'b0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every write strobe is matched against the next expected {words, addr, data}
  always @(negedge clk) begin
    if (rom_we === 1'b1) begin
      checks++;
      if (rx_ready !== 1'b0) begin
        failures++;
        $display("FAIL ready_during_we got=%b exp=0", rx_ready);
      end
      checks++;
      if (rom_addr[1:0] !== 2'b00) begin
        failures++;
        $display("FAIL addr_aligned got=%h", rom_addr);
      end
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write addr=%h data=%h words=%0d", rom_addr, rom_data, words);
      end else begin
        logic [79:0] e;
        e = exp_q.pop_front();
        if ({words, rom_addr, rom_data} !== e) begin
          failures++;
          $display("FAIL rom_write got words=%0d addr=%h data=%h exp words=%0d addr=%h data=%h",
                   words, rom_addr, rom_data, e[79:64], e[63:32], e[31:0]);
        end
      end
    end
  end

  // Driver: present a byte and hold it until the loader takes it (bounded)
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    while (rx_ready !== 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (rx_ready !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL send_stall byte=%h ready=%b exp=1", b, rx_ready);
    end
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input int n, input logic [7:0] bad);
    logic [15:0] len;
    logic [7:0]  cs;
    logic [31:0] w;
    len = 16'(n);
    cs  = len[7:0] ^ len[15:8];
    send_byte(LDR_MAGIC);
    checks++;
    if (boot_err !== 1'b0 || dbg_state !== LDR_LEN_LO) begin
      failures++;
      $display("FAIL after_magic err=%b state=%0d exp err=0 state=%0d", boot_err, dbg_state, LDR_LEN_LO);
    end
    send_byte(len[7:0]);
    send_byte(len[15:8]);
    for (int k = 0; k < n; k++) begin
      w = frame_words[k];
      for (int j = 0; j < 4; j++) begin
        cs = cs ^ w[8*j +: 8];
        send_byte(w[8*j +: 8]);
      end
      exp_q.push_back({16'(k + 1), TB_BASE + 32'(4 * k), w});
    end
    checks++;
    if (core_hold !== 1'b1) begin
      failures++;
      $display("FAIL hold_before_csum got=%b exp=1", core_hold);
    end
    send_byte(cs ^ bad);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({rom_we, rom_addr, rom_data, core_hold, boot_done, boot_err, words, rx_ready}
        !== {1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b1} || dbg_state !== LDR_IDLE) begin
      failures++;
      $display("FAIL reset_values we=%b addr=%h data=%h hold=%b done=%b err=%b words=%0d ready=%b state=%0d",
               rom_we, rom_addr, rom_data, core_hold, boot_done, boot_err, words, rx_ready, dbg_state);
    end
  endtask

  task automatic test_basic_frame();
    logic [7:0] bytes [12];
    bytes = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00, 8'h7E};
    do_reset();
    for (int i = 0; i < 12; i++) begin
      if (i == 11) begin
        checks++;
        if (core_hold !== 1'b1) begin
          failures++;
          $display("FAIL basic_hold_pre got=%b exp=1", core_hold);
        end
      end
      send_byte(bytes[i]);
      if (i == 6)  exp_q.push_back({16'd1, 32'h0000_0000, 32'h0000_0013});
      if (i == 10) exp_q.push_back({16'd2, 32'h0000_0004, 32'h0000_006F});
    end
    checks++;
    if (core_hold !== 1'b0 || boot_done !== 1'b1 || boot_err !== 1'b0 || words !== 16'd2) begin
      failures++;
      $display("FAIL basic_done hold=%b done=%b err=%b words=%0d exp 0 1 0 2", core_hold, boot_done, boot_err, words);
    end
    @(negedge clk);
    checks++;
    if (rx_ready !== 1'b0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL basic_tail ready=%b pending=%0d exp ready=0 pending=0", rx_ready, exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_bad_csum();
    do_reset();
    frame_words[0] = 32'h0000_0013;
    frame_words[1] = 32'h0000_006F;
    send_frame(2, 8'h01);
    checks++;
    if (boot_err !== 1'b1 || core_hold !== 1'b1 || boot_done !== 1'b0 || dbg_state !== LDR_ERR) begin
      failures++;
      $display("FAIL bad_csum err=%b hold=%b done=%b state=%0d exp 1 1 0 %0d", boot_err, core_hold, boot_done, dbg_state, LDR_ERR);
    end
    send_frame(2, 8'h00);
    checks++;
    if (boot_done !== 1'b1 || boot_err !== 1'b0 || core_hold !== 1'b0 || words !== 16'd2) begin
      failures++;
      $display("FAIL resend done=%b err=%b hold=%b words=%0d exp 1 0 0 2", boot_done, boot_err, core_hold, words);
    end
  endtask

  task automatic test_len_limit();
    do_reset();
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h10);
    checks++;
    if (boot_err !== 1'b1 || dbg_state !== LDR_ERR || core_hold !== 1'b1) begin
      failures++;
      $display("FAIL len_over err=%b state=%0d hold=%b exp 1 %0d 1", boot_err, dbg_state, core_hold, LDR_ERR);
    end
    send_byte(8'h00);
    send_byte(8'h11);
    checks++;
    if (boot_err !== 1'b1 || rx_ready !== 1'b1 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL err_drop err=%b ready=%b pending=%0d exp 1 1 0", boot_err, rx_ready, exp_q.size());
    end
    // N == MAX_WORDS is still accepted
    do_reset();
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h10);
    checks++;
    if (dbg_state !== LDR_DATA || boot_err !== 1'b0) begin
      failures++;
      $display("FAIL len_max state=%0d err=%b exp %0d 0", dbg_state, boot_err, LDR_DATA);
    end
  endtask

  task automatic test_zero_len();
    do_reset();
    send_byte(8'h11);
    send_byte(8'h22);
    checks++;
    if (dbg_state !== LDR_IDLE || words !== 16'd0) begin
      failures++;
      $display("FAIL junk_ignored state=%0d words=%0d exp %0d 0", dbg_state, words, LDR_IDLE);
    end
    send_frame(0, 8'h00);
    checks++;
    if (boot_done !== 1'b1 || words !== 16'd0 || core_hold !== 1'b0) begin
      failures++;
      $display("FAIL zero_len done=%b words=%0d hold=%b exp 1 0 0", boot_done, words, core_hold);
    end
  endtask

  task automatic test_timeout();
    // One cycle short of the budget: frame completes
    do_reset();
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h13); send_byte(8'h00);
    repeat (TB_TIMEOUT - 1) @(posedge clk);
    #1;
    send_byte(8'h00); send_byte(8'h00);
    exp_q.push_back({16'd1, 32'h0000_0000, 32'h0000_0013});
    send_byte(8'h6F); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    exp_q.push_back({16'd2, 32'h0000_0004, 32'h0000_006F});
    send_byte(8'h7E);
    checks++;
    if (boot_done !== 1'b1 || boot_err !== 1'b0) begin
      failures++;
      $display("FAIL stall_short done=%b err=%b exp 1 0", boot_done, boot_err);
    end
    // Full budget: loader gives up
    do_reset();
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h13); send_byte(8'h00);
    repeat (TB_TIMEOUT - 1) @(posedge clk);
    @(negedge clk);
    checks++;
    if (boot_err !== 1'b0 || dbg_state !== LDR_DATA) begin
      failures++;
      $display("FAIL stall_edge err=%b state=%0d exp 0 %0d", boot_err, dbg_state, LDR_DATA);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (boot_err !== 1'b1 || core_hold !== 1'b1) begin
      failures++;
      $display("FAIL stall_timeout err=%b hold=%b exp 1 1", boot_err, core_hold);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_async_reset();
    do_reset();
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    exp_q.push_back({16'd1, 32'h0000_0000, 32'h0000_0013});
    send_byte(8'h6F);
    #3;
    rst = 1'b0;
    #1;
    checks++;
    if ({rom_we, rom_addr, rom_data, core_hold, boot_done, boot_err, words}
        !== {1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 16'h0} || dbg_state !== LDR_IDLE) begin
      failures++;
      $display("FAIL async_reset we=%b addr=%h data=%h hold=%b done=%b err=%b words=%0d state=%0d",
               rom_we, rom_addr, rom_data, core_hold, boot_done, boot_err, words, dbg_state);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) frame_words[k] = $urandom;
    send_frame(3, 8'h00);
    checks++;
    if (boot_done !== 1'b1 || words !== 16'd3 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL reload_after_reset done=%b words=%0d pending=%0d exp 1 3 0", boot_done, words, exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int n;
    do_reset();
    n = $urandom_range(5, 9);
    for (int k = 0; k < n; k++) frame_words[k] = $urandom;
    send_frame(n, 8'h00);
    @(negedge clk);
    checks++;
    if (boot_done !== 1'b1 || words !== 16'(n) || exp_q.size() != 0) begin
      failures++;
      $display("FAIL back_to_back done=%b words=%0d pending=%0d exp 1 %0d 0", boot_done, words, exp_q.size(), n);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    failures++;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic_frame();
    test_bad_csum();
    test_len_limit();
    test_zero_len();
    test_timeout();
    test_async_reset();
    test_back_to_back();
    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
